fp_mul_sigcalc: RTL

Iterative radix-4 Booth significand multiplier. It is the multiply counterpart of the radix-4 SRT significand divider in the FP datapath.
- Takes two normalized (sig_width+1)-bit significands and computes the full product.
- Product is built MSB-first in carry-save form, with one final carry-propagate add.
- Returns the normalized significand with guard/round/sticky bits and an exponent-increment flag for the rounding stage.
- Ready/valid handshake on both sides, so it can sit between an operand register and the shared rounder.

---
 rtl/fp_mul_pkg.sv | 14 +
 rtl/booth_recoder.sv | 25 ++
 rtl/csa.sv | 15 +
 rtl/fp_mul_sigcalc.sv | 127 ++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared types and sizing helpers for the Booth significand multiplier
package fp_mul_pkg;
  typedef enum logic [1:0] {IDLE, ITER, FINAL, HOLD} state_t;
  typedef struct packed {
    logic zero;
    logic p1;
    logic p2;
    logic m1;
    logic m2;
  } booth_t;
  function automatic int booth_digits(input int sig_width);
    return (sig_width + 1) / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: radix-4 Booth digit recode and signed multiple selection
// Ports: bits = y(2i+1,2i,2i-1), x multiplicand; digit one-hot, mult = digit*x
//        (one's complement for negative digits), cin = +1 completing the negation.
module booth_recoder
  import fp_mul_pkg::*;
#(
  parameter int N = 24,
  parameter int W = 2 * N + 4
) (
  input  logic [2:0]   bits,
  input  logic [N-1:0] x,
  output booth_t       digit,
  output logic [W-1:0] mult,
  output logic         cin
);
  logic [W-1:0] xe;
  assign xe = W'(x);
  assign digit = '{zero: bits == 3'b000 || bits == 3'b111,
                   p1:   bits == 3'b001 || bits == 3'b010,
                   p2:   bits == 3'b011,
                   m1:   bits == 3'b101 || bits == 3'b110,
                   m2:   bits == 3'b100};
  assign mult = digit.p1 ? xe : digit.p2 ? xe << 1 : digit.m1 ? ~xe : digit.m2 ? ~(xe << 1) : '0;
  assign cin  = digit.m1 || digit.m2;
endmodule

// File: rtl/csa.sv
// csa: 3:2 carry-save adder; co is already weighted x2 with ci filling its LSB
// Ports: a/b/c addends, ci carry-in at LSB, s sum vector, co shifted carry vector.
module csa #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic [W-1:0] co
);
  assign s  = a ^ b ^ c;
  assign co = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), ci};
endmodule

// File: rtl/fp_mul_sigcalc.sv
// fp_mul_sigcalc: iterative radix-4 Booth significand multiplier with G/R/S normalization
// Ports: clk, resetn (async, active-low), enable (global stall);
//        in_valid/in_ready/x/y operand side; out_valid/out_ready/product/guard_bit/
//        round_bit/sticky_bit/count result side (count=1 means exponent +1).
// FP_MUL_SIGCALC_EARLY_EXIT_EN: leave ITER once the unrecoded multiplier bits are all zero.
module fp_mul_sigcalc
  import fp_mul_pkg::*;
#(
  parameter int sig_width        = 23,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [sig_width:0] x,
  input  logic [sig_width:0] y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [sig_width:0] product,
  output logic               guard_bit,
  output logic               round_bit,
  output logic               sticky_bit,
  output logic               count
);
  localparam int N      = sig_width + 1;
  localparam int W      = 2 * N + 4;
  localparam int DPC    = DIGITS_PER_CYCLE;
  localparam int DIGITS = booth_digits(sig_width);
  localparam int ITERS  = (DIGITS + DPC - 1) / DPC;
  // digit count padded to whole iterations; the extra top digits see only zero bits
  localparam int NDIG   = ITERS * DPC;
  localparam int YW     = 2 * NDIG;
  localparam int CW     = $clog2(NDIG + 1);
  state_t state;
  logic [N-1:0] xr;
  logic [YW-1:0] yr;
  logic [W-1:0] s, c;
  logic [CW-1:0] dcnt, dnext;
  logic last;
  logic [2*N-1:0] p;
  logic [W-1:0] ss [DPC+1];
  logic [W-1:0] cc [DPC+1];
  logic [YW-1:0] ys [DPC+1];
  assign in_ready  = state == IDLE;
  assign out_valid = state == HOLD;
  assign ss[0] = s;
  assign cc[0] = c;
  assign ys[0] = yr;
  // yr shifts left two bits per digit, so its top three bits are always the next digit window
  for (genvar d = 0; d < DPC; d++) begin : g_dig
    booth_t dig;
    logic [W-1:0] mult, csum, ccar;
    logic cin;
    booth_recoder #(.N(N), .W(W)) u_rec (
      .bits (ys[d][YW-1 -: 3]),
      .x    (xr),
      .digit(dig),
      .mult (mult),
      .cin  (cin)
    );
    csa #(.W(W)) u_csa (
      .a (ss[d] << 2),
      .b (cc[d] << 2),
      .c (mult),
      .ci(cin),
      .s (csum),
      .co(ccar)
    );
    always_comb assert ($onehot(dig));
    assign ss[d+1] = csum;
    assign cc[d+1] = ccar;
    assign ys[d+1] = ys[d] << 2;
  end
  assign dnext = dcnt + CW'(DPC);
`ifdef FP_MUL_SIGCALC_EARLY_EXIT_EN
  assign last = dnext == CW'(NDIG) || ys[DPC] == '0;
  // skipped digits are all zero, so the missing 4^k scaling is a plain shift
  assign p = (s[2*N-1:0] + c[2*N-1:0]) << {CW'(NDIG) - dcnt, 1'b0};
`else
  assign last = dnext == CW'(NDIG);
  assign p = s[2*N-1:0] + c[2*N-1:0];
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      xr         <= '0;
      yr         <= '0;
      s          <= '0;
      c          <= '0;
      dcnt       <= '0;
      product    <= '0;
      guard_bit  <= 1'b0;
      round_bit  <= 1'b0;
      sticky_bit <= 1'b0;
      count      <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: if (in_valid) begin
          xr    <= x;
          yr    <= YW'(y);
          s     <= '0;
          c     <= '0;
          dcnt  <= '0;
          state <= ITER;
        end
        ITER: begin
          s     <= ss[DPC];
          c     <= cc[DPC];
          yr    <= ys[DPC];
          dcnt  <= dnext;
          state <= last ? FINAL : ITER;
        end
        FINAL: begin
          count      <= p[2*N-1];
          product    <= p[2*N-1] ? p[2*N-1 -: N] : p[2*N-2 -: N];
          guard_bit  <= p[2*N-1] ? p[N-1] : p[N-2];
          round_bit  <= p[2*N-1] ? p[N-2] : p[N-3];
          sticky_bit <= p[2*N-1] ? |p[N-3:0] : |p[N-4:0];
          state      <= HOLD;
        end
        default: if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule
